wb_multi: RTL and testbench

- Parametrised successor to the single-channel write-back stage.
- Accepts completed instructions from NCH independent producer channels (e.g. ALU, load unit, mul/div) into per-channel FIFOs.
- Round-robin arbitrates them onto the single register-file write port through a registered output.
- Produces an in-order-per-channel retire pulse and a busy indication for hazard logic.

---
 rtl/wb_multi.sv | 170 +++++++++++++++++
 tb/tb_wb_multi.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_multi.sv
// Multi-channel write-back: per-channel FIFOs, round-robin arbitration onto one
// register-file write port. Optional macro WB_RETIRE_CNT_EN adds a 64-bit retire counter.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_AW
`define REG_AW 5
`endif

module wb_multi #(
  parameter int NCH    = 2,
  parameter int DEPTH  = 2,
  parameter int XLEN   = `XLEN,
  parameter int REG_AW = `REG_AW
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  wb_flush,
  input  logic [NCH-1:0]        wb_ch_valid,
  output logic [NCH-1:0]        wb_ch_ready,
  input  logic [NCH-1:0]        wb_ch_rd_write,
  input  logic [NCH*REG_AW-1:0] wb_ch_rd_addr,
  input  logic [NCH*XLEN-1:0]   wb_ch_rd_data,
  input  logic [NCH*XLEN-1:0]   wb_ch_pc,
  output logic                  wb_rd_write,
  output logic [REG_AW-1:0]     wb_rd_addr,
  output logic [XLEN-1:0]       wb_rd_wdata,
  output logic                  wb_retire,
  output logic [XLEN-1:0]       wb_retire_pc,
  output logic                  wb_busy
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           wb_instret
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [NCH-1:0]        nonempty;
  logic [NCH-1:0]        push;
  logic [NCH-1:0]        pop;
  logic [NCH-1:0]        head_wr;
  logic [NCH*REG_AW-1:0] head_addr;
  logic [NCH*XLEN-1:0]   head_data;
  logic [NCH*XLEN-1:0]   head_pc;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic          grant_vld;

  for (genvar i = 0; i < NCH; i++) begin : g_fifo
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              wr_mem   [DEPTH];
    logic [REG_AW-1:0] addr_mem [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];
    logic [XLEN-1:0]   pc_mem   [DEPTH];

    // Ready depends on count only, so a full FIFO refuses a push even while popped.
    assign wb_ch_ready[i] = (cnt != FULL);
    assign push[i]        = wb_ch_valid[i] & wb_ch_ready[i];
    assign nonempty[i]    = (cnt != '0);
    assign pop[i]         = grant_vld & (grant == PW'(i)) & ~wb_flush;

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else if (wb_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push[i] && !wb_flush) begin
        wr_mem[wr_ptr]   <= wb_ch_rd_write[i];
        addr_mem[wr_ptr] <= wb_ch_rd_addr[i*REG_AW +: REG_AW];
        data_mem[wr_ptr] <= wb_ch_rd_data[i*XLEN +: XLEN];
        pc_mem[wr_ptr]   <= wb_ch_pc[i*XLEN +: XLEN];
      end
    end

    assign head_wr[i]                    = wr_mem[rd_ptr];
    assign head_addr[i*REG_AW +: REG_AW] = addr_mem[rd_ptr];
    assign head_data[i*XLEN +: XLEN]     = data_mem[rd_ptr];
    assign head_pc[i*XLEN +: XLEN]       = pc_mem[rd_ptr];
  end

  // Pick the non-empty channel closest to rr_ptr going upward modulo NCH.
  always_comb begin
    int rr_int;
    int best;
    int d;
    grant     = '0;
    grant_vld = 1'b0;
    best      = NCH;
    rr_int    = int'(rr_ptr);
    for (int c = 0; c < NCH; c++) begin
      d = c - rr_int;
      if (d < 0) d = d + NCH;
      if (nonempty[c] && (d < best)) begin
        best      = d;
        grant     = PW'(c);
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr <= '0;
    end else if (grant_vld && !wb_flush) begin
      rr_ptr <= (grant == PW'(NCH-1)) ? '0 : grant + 1'b1;
    end
  end

  logic              sel_wr;
  logic [REG_AW-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;
  logic [XLEN-1:0]   sel_pc;

  assign sel_wr   = head_wr[grant];
  assign sel_addr = head_addr[int'(grant)*REG_AW +: REG_AW];
  assign sel_data = head_data[int'(grant)*XLEN +: XLEN];
  assign sel_pc   = head_pc[int'(grant)*XLEN +: XLEN];

  // Address/data hold when idle; only the strobes drop.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wb_rd_write  <= 1'b0;
      wb_rd_addr   <= '0;
      wb_rd_wdata  <= '0;
      wb_retire    <= 1'b0;
      wb_retire_pc <= '0;
    end else if (grant_vld && !wb_flush) begin
      wb_rd_write  <= sel_wr & (sel_addr != '0);
      wb_rd_addr   <= sel_addr;
      wb_rd_wdata  <= sel_data;
      wb_retire    <= 1'b1;
      wb_retire_pc <= sel_pc;
    end else begin
      wb_rd_write  <= 1'b0;
      wb_retire    <= 1'b0;
    end
  end

  assign wb_busy = (|nonempty) | wb_retire;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)         wb_instret <= '0;
    else if (wb_retire) wb_instret <= wb_instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_multi.sv
// Self-checking bench for wb_multi (NCH=2, DEPTH=2): vector table, scoreboard
// monitor and hand-written latency, interleave, backpressure, flush and reset sequences.
module tb_wb_multi;
  localparam int NCH = 2, DEPTH = 2, XLEN = 32, RAW = 5;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            wb_flush = 1'b0;
  logic [NCH-1:0]  wb_ch_valid = '0;
  logic [NCH-1:0]  wb_ch_ready;
  logic [NCH-1:0]  wb_ch_rd_write = '0;
  logic [NCH*RAW-1:0]  wb_ch_rd_addr = '0;
  logic [NCH*XLEN-1:0] wb_ch_rd_data = '0;
  logic [NCH*XLEN-1:0] wb_ch_pc = '0;
  logic            wb_rd_write;
  logic [RAW-1:0]  wb_rd_addr;
  logic [XLEN-1:0] wb_rd_wdata;
  logic            wb_retire;
  logic [XLEN-1:0] wb_retire_pc;
  logic            wb_busy;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]     wb_instret;
`endif

  wb_multi #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(RAW)) dut (
    .clk(clk), .rst_b(rst_b), .wb_flush(wb_flush),
    .wb_ch_valid(wb_ch_valid), .wb_ch_ready(wb_ch_ready),
    .wb_ch_rd_write(wb_ch_rd_write), .wb_ch_rd_addr(wb_ch_rd_addr),
    .wb_ch_rd_data(wb_ch_rd_data), .wb_ch_pc(wb_ch_pc),
    .wb_rd_write(wb_rd_write), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
    .wb_retire(wb_retire), .wb_retire_pc(wb_retire_pc), .wb_busy(wb_busy)
`ifdef WB_RETIRE_CNT_EN
    , .wb_instret(wb_instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              wr;
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } ent_t;

  typedef struct {
    int   ch;
    ent_t in;
    bit   exp_wr;
  } vec_t;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   ret_cyc[$];
  bit   seen_full0 = 0;
  ent_t exp_q[$];
  ent_t src_q[2][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every retire must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_b) begin
      if (!wb_ch_ready[0]) seen_full0 = 1;
      if (wb_retire) begin
        ret_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_retire: got pc %0h expected no retire", wb_retire_pc);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("sb_retire_pc", wb_retire_pc, e.pc);
          chk("sb_rd_write", wb_rd_write, e.wr);
          chk("sb_rd_addr", wb_rd_addr, e.addr);
          chk("sb_rd_wdata", wb_rd_wdata, e.data);
        end
      end
    end
  end

  task automatic drive_ch(input int ch, input bit v, input ent_t e);
    wb_ch_valid[ch] = v;
    wb_ch_rd_write[ch] = e.wr;
    wb_ch_rd_addr[ch*RAW +: RAW] = e.addr;
    wb_ch_rd_data[ch*XLEN +: XLEN] = e.data;
    wb_ch_pc[ch*XLEN +: XLEN] = e.pc;
  endtask

  function automatic ent_t mk(input bit wr, input int addr, input logic [31:0] data, input logic [31:0] pc);
    ent_t e;
    e.wr = wr; e.addr = RAW'(addr); e.data = data; e.pc = pc;
    return e;
  endfunction

  // Producers hold an entry until ready was high at the edge, then drain the scoreboard.
  task automatic run_src();
    int  t = 0;
    bit  acc[2];
    ent_t z;
    z = mk(0, 0, 0, 0);
    while ((src_q[0].size() != 0 || src_q[1].size() != 0) && t < 300) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (src_q[ch].size() != 0) drive_ch(ch, 1, src_q[ch][0]);
        else drive_ch(ch, 0, z);
        acc[ch] = wb_ch_valid[ch] && wb_ch_ready[ch];
      end
      @(posedge clk);
      for (int ch = 0; ch < 2; ch++) if (acc[ch]) void'(src_q[ch].pop_front());
      t++;
    end
    @(negedge clk);
    drive_ch(0, 0, z);
    drive_ch(1, 0, z);
    if (t >= 300) chk("src_timeout", 1, 0);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    ent_t z;
    z = mk(0, 0, 0, 0);
    @(negedge clk);
    rst_b = 0;
    wb_flush = 0;
    drive_ch(0, 0, z);
    drive_ch(1, 0, z);
    exp_q.delete();
    src_q[0].delete();
    src_q[1].delete();
    #2 rst_b = 1;
  endtask

  vec_t vt[6];
  int   n_ret0;
  int   bad_ret;

  initial begin
    ent_t z, e0, e1;
    z = mk(0, 0, 0, 0);
    vt[0] = '{ch: 0, in: mk(1, 3,  32'h1111_0000, 32'h200), exp_wr: 1};
    vt[1] = '{ch: 1, in: mk(1, 31, 32'hCAFE_F00D, 32'h204), exp_wr: 1};
    vt[2] = '{ch: 0, in: mk(1, 0,  32'h55,        32'h208), exp_wr: 0};
    vt[3] = '{ch: 1, in: mk(0, 9,  32'hA5A5_A5A5, 32'h20C), exp_wr: 0};
    vt[4] = '{ch: 1, in: mk(1, 0,  32'h77,        32'h210), exp_wr: 0};
    vt[5] = '{ch: 0, in: mk(1, 17, 32'hFFFF_FFFF, 32'h214), exp_wr: 1};

    // Reset state
    repeat (2) @(negedge clk);
    rst_b = 1;
    #1;
    chk("rst_retire", wb_retire, 0);
    chk("rst_rd_write", wb_rd_write, 0);
    chk("rst_rd_addr", wb_rd_addr, 0);
    chk("rst_rd_wdata", wb_rd_wdata, 0);
    chk("rst_retire_pc", wb_retire_pc, 0);
    chk("rst_busy", wb_busy, 0);
    chk("rst_ready", wb_ch_ready, 2'b11);

    // Single-channel latency: push at edge 1, visible only after edge 2
    @(negedge clk);
    e0 = mk(1, 5, 32'hDEAD_BEEF, 32'h100);
    drive_ch(0, 1, e0);
    exp_q.push_back(e0);
    @(posedge clk); #1;
    drive_ch(0, 0, z);
    chk("lat_e1_retire", wb_retire, 0);
    chk("lat_e1_busy", wb_busy, 1);
    @(posedge clk); #1;
    chk("lat_e2_retire", wb_retire, 1);
    chk("lat_e2_rd_write", wb_rd_write, 1);
    chk("lat_e2_addr", wb_rd_addr, 5);
    chk("lat_e2_wdata", wb_rd_wdata, 32'hDEAD_BEEF);
    chk("lat_e2_pc", wb_retire_pc, 32'h100);
    @(posedge clk); #1;
    chk("lat_e3_retire", wb_retire, 0);
    chk("lat_e3_rd_write", wb_rd_write, 0);
    chk("lat_e3_addr_hold", wb_rd_addr, 5);
    chk("lat_e3_busy", wb_busy, 0);

    // Vector table, one entry at a time
    for (int i = 0; i < 6; i++) begin
      ent_t x;
      src_q[vt[i].ch].push_back(vt[i].in);
      x = vt[i].in;
      x.wr = vt[i].exp_wr;
      exp_q.push_back(x);
      run_src();
    end

    // Interleave: 3 entries per channel, rr_ptr=0 -> ch0,ch1,... with no gaps
    do_reset();
    for (int k = 0; k < 3; k++) begin
      e0 = mk(1, 1 + k, 32'hA000 + k, 32'h1000 + 8 * k);
      e1 = mk(1, 10 + k, 32'hB000 + k, 32'h2000 + 8 * k);
      src_q[0].push_back(e0);
      src_q[1].push_back(e1);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
    end
    ret_cyc.delete();
    run_src();
    chk("il_retire_count", ret_cyc.size(), 6);
    if (ret_cyc.size() == 6) chk("il_no_gaps", ret_cyc[5] - ret_cyc[0], 5);

    // Backpressure: ch0 fills while ch1 shares the port
    do_reset();
    seen_full0 = 0;
    for (int k = 0; k < 4; k++) begin
      e0 = mk(1, 20 + k, 32'hC000 + k, 32'h3000 + 4 * k);
      e1 = mk(1, 24 + k, 32'hD000 + k, 32'h4000 + 4 * k);
      src_q[0].push_back(e0);
      src_q[1].push_back(e1);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
    end
    run_src();
    chk("bp_ch0_full_seen", seen_full0, 1);

    // Flush with two buffered entries and a concurrent push
    do_reset();
    @(negedge clk);
    drive_ch(0, 1, mk(1, 7, 32'h7777, 32'h500));
    drive_ch(1, 1, mk(1, 8, 32'h8888, 32'h504));
    @(negedge clk);
    chk("fl_busy_before", wb_busy, 1);
    drive_ch(1, 0, z);
    drive_ch(0, 1, mk(1, 9, 32'h9999, 32'h508));
    wb_flush = 1;
    @(negedge clk);
    wb_flush = 0;
    drive_ch(0, 0, z);
    chk("fl_busy_after", wb_busy, 0);
    chk("fl_retire_after", wb_retire, 0);
    chk("fl_rd_write_after", wb_rd_write, 0);
    chk("fl_ready_after", wb_ch_ready, 2'b11);
    bad_ret = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_retire || wb_rd_write || wb_busy) bad_ret++;
    end
    chk("fl_quiet", bad_ret, 0);

`ifdef WB_RETIRE_CNT_EN
    // Retire counter survives flush
    do_reset();
    for (int k = 0; k < 10; k++) begin
      e0 = mk(1, 2, 32'hE000 + k, 32'h6000 + 4 * k);
      src_q[0].push_back(e0);
      exp_q.push_back(e0);
    end
    run_src();
    @(negedge clk);
    wb_flush = 1;
    @(negedge clk);
    wb_flush = 0;
    for (int k = 0; k < 3; k++) begin
      e0 = mk(1, 3, 32'hF000 + k, 32'h7000 + 4 * k);
      src_q[0].push_back(e0);
      exp_q.push_back(e0);
    end
    run_src();
    repeat (2) @(negedge clk);
    chk("instret_13", wb_instret, 64'd13);
`endif

    // Reset mid-stream clears outputs at once and drops buffered entries
    do_reset();
    @(negedge clk);
    e0 = mk(1, 12, 32'h1234_5678, 32'h800);
    drive_ch(0, 1, e0);
    drive_ch(1, 1, mk(1, 13, 32'h2222, 32'h804));
    exp_q.push_back(e0);
    @(negedge clk);
    drive_ch(0, 1, mk(1, 14, 32'h3333, 32'h808));
    drive_ch(1, 1, mk(1, 15, 32'h4444, 32'h80C));
    @(negedge clk);
    drive_ch(0, 0, z);
    drive_ch(1, 0, z);
    chk("mr_retire_before", wb_retire, 1);
    #2 rst_b = 0;
    #1;
    chk("mr_retire", wb_retire, 0);
    chk("mr_rd_write", wb_rd_write, 0);
    chk("mr_rd_addr", wb_rd_addr, 0);
    chk("mr_rd_wdata", wb_rd_wdata, 0);
    chk("mr_retire_pc", wb_retire_pc, 0);
    chk("mr_busy", wb_busy, 0);
    exp_q.delete();
    #2 rst_b = 1;
    n_ret0 = ret_cyc.size();
    repeat (5) @(negedge clk);
    chk("mr_no_retire_after", ret_cyc.size() - n_ret0, 0);
    chk("mr_ready_after", wb_ch_ready, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
